fnd_scan_decoder: RTL

//  Receiving end of the FND scan interface: samples the time-multiplexed fndCom/fndFont lines

---
 rtl/fnd_pkg.sv | 29 ++
 rtl/fnd_seg_to_bcd.sv | 29 ++
 rtl/fnd_scan_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan decoder.
// Segment patterns are active-low {g,f,e,d,c,b,a}; commons are active-low one-hot.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [3:0] COM_D0 = 4'b1110;
    localparam logic [3:0] COM_D1 = 4'b1101;
    localparam logic [3:0] COM_D2 = 4'b1011;
    localparam logic [3:0] COM_D3 = 4'b0111;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        DONE
    } state_t;

endpackage

// File: rtl/fnd_seg_to_bcd.sv
// Combinational 7-segment pattern to BCD nibble decoder.
// Any pattern outside the ten digit shapes is reported as invalid.
module fnd_seg_to_bcd
    import fnd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_valid,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_valid  = 1'b1;
        o_nibble = 4'd0;
        case (i_seg)
            SEG_0:   o_nibble = 4'd0;
            SEG_1:   o_nibble = 4'd1;
            SEG_2:   o_nibble = 4'd2;
            SEG_3:   o_nibble = 4'd3;
            SEG_4:   o_nibble = 4'd4;
            SEG_5:   o_nibble = 4'd5;
            SEG_6:   o_nibble = 4'd6;
            SEG_7:   o_nibble = 4'd7;
            SEG_8:   o_nibble = 4'd8;
            SEG_9:   o_nibble = 4'd9;
            default: o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Rebuilds the 4-digit decimal number from a multiplexed FND scan (com/font lines).
// Optional FND_DP_CAPTURE_EN: capture and publish per-digit decimal points; otherwise dp is 0.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int STABLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fndCom,
    input  logic [7:0]  fndFont,
    output logic [15:0] bcd,
    output logic [13:0] value,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    localparam int TIME_W = $clog2(TIMEOUT_CYC);

    logic [3:0]                   r_com;
    logic [7:0]                   r_font;
    logic [STAB_W-1:0]            r_stab;
    logic [NUM_DIGITS-1:0][3:0]   r_digit;
    logic [NUM_DIGITS-1:0]        r_err;
    logic [NUM_DIGITS-1:0]        r_seen;
    state_t                       r_state;
    state_t                       w_stateNext;
    logic [1:0]                   r_cvtIdx;
    logic [NUM_DIGITS-1:0][3:0]   r_work;
    logic                         r_workErr;
    logic [13:0]                  r_acc;
    logic [15:0]                  r_bcd;
    logic [13:0]                  r_value;
    logic                         r_frameErr;
    logic [TIME_W-1:0]            r_timeCnt;
    logic                         r_stale;

    logic                         w_change;
    logic                         w_comValid;
    logic [1:0]                   w_digitIdx;
    logic                         w_capture;
    logic                         w_segValid;
    logic [3:0]                   w_segNibble;
    logic                         w_snapshot;
    logic                         w_publish;
    logic                         w_frameValid;
    logic [13:0]                  w_accNext;

    // The counter saturates one above the capture point so the strobe fires once per stable hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_com  <= 4'hF;
            r_font <= 8'hFF;
            r_stab <= '0;
        end else begin
            r_com  <= fndCom;
            r_font <= fndFont;
            if (w_change)
                r_stab <= '0;
            else if (r_stab != STAB_W'(STABLE_CYC))
                r_stab <= r_stab + 1'b1;
        end
    end

    assign w_change = (fndCom != r_com) || (fndFont != r_font);

    always_comb begin
        w_comValid = 1'b1;
        w_digitIdx = 2'd0;
        case (r_com)
            COM_D0:  w_digitIdx = 2'd0;
            COM_D1:  w_digitIdx = 2'd1;
            COM_D2:  w_digitIdx = 2'd2;
            COM_D3:  w_digitIdx = 2'd3;
            default: w_comValid = 1'b0;
        endcase
    end

    fnd_seg_to_bcd u_segToBcd (
        .i_seg    (r_font[6:0]),
        .o_valid  (w_segValid),
        .o_nibble (w_segNibble)
    );

    assign w_capture  = (r_stab == STAB_W'(STABLE_CYC - 1)) && w_comValid;
    assign w_snapshot = (r_state == COLLECT) && (r_seen == '1);
    assign w_publish  = (r_state == CONVERT) && (r_cvtIdx == 2'd0) && !r_workErr;
    assign w_accNext  = r_acc * 14'd10 + {10'd0, r_work[r_cvtIdx]};

    // A capture coinciding with the snapshot lands after the clear, so it belongs to the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
            r_err   <= '0;
            r_seen  <= '0;
        end else begin
            if (w_snapshot) begin
                r_seen <= '0;
                r_err  <= '0;
            end
            if (w_capture) begin
                r_digit[w_digitIdx] <= w_segNibble;
                r_err[w_digitIdx]   <= ~w_segValid;
                r_seen[w_digitIdx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= COLLECT;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext  = r_state;
        w_frameValid = 1'b0;
        case (r_state)
            COLLECT: if (r_seen == '1) w_stateNext = CONVERT;
            CONVERT: if (r_cvtIdx == 2'd0) w_stateNext = DONE;
            DONE: begin
                w_frameValid = 1'b1;
                w_stateNext  = COLLECT;
            end
            default: w_stateNext = COLLECT;
        endcase
    end

    // Results are written on the last convert step so they are already visible during DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cvtIdx   <= 2'd0;
            r_work     <= '0;
            r_workErr  <= 1'b0;
            r_acc      <= '0;
            r_bcd      <= '0;
            r_value    <= '0;
            r_frameErr <= 1'b0;
        end else begin
            if (w_snapshot) begin
                r_work    <= r_digit;
                r_workErr <= |r_err;
                r_acc     <= '0;
                r_cvtIdx  <= 2'd3;
            end
            if (r_state == CONVERT) begin
                r_acc    <= w_accNext;
                r_cvtIdx <= r_cvtIdx - 2'd1;
                if (r_cvtIdx == 2'd0)
                    r_frameErr <= r_workErr;
            end
            if (w_publish) begin
                r_bcd   <= r_work;
                r_value <= w_accNext;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeCnt <= '0;
            r_stale   <= 1'b1;
        end else if (w_frameValid) begin
            r_timeCnt <= '0;
            if (!r_frameErr)
                r_stale <= 1'b0;
        end else if (r_timeCnt == TIME_W'(TIMEOUT_CYC - 1)) begin
            r_stale <= 1'b1;
        end else begin
            r_timeCnt <= r_timeCnt + 1'b1;
        end
    end

`ifdef FND_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] r_dpShadow;
    logic [NUM_DIGITS-1:0] r_workDp;
    logic [NUM_DIGITS-1:0] r_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dpShadow <= '0;
            r_workDp   <= '0;
            r_dp       <= '0;
        end else begin
            if (w_capture)
                r_dpShadow[w_digitIdx] <= ~r_font[7];
            if (w_snapshot)
                r_workDp <= r_dpShadow;
            if (w_publish)
                r_dp <= r_workDp;
        end
    end

    assign dp = r_dp;
`else
    assign dp = '0;
`endif

    assign bcd         = r_bcd;
    assign value       = r_value;
    assign frame_valid = w_frameValid;
    assign frame_err   = r_frameErr;
    assign stale       = r_stale;

endmodule
